// File: rtl/riscv_id_pkg.sv
// Shared constants and types for the RV32I decode stage: opcode and funct3
// encodings (the same funct3 encoding riscv_ex consumes) and the output bundle.
package riscv_id_pkg;

  localparam int RV_XLEN  = 32;
  localparam int RV_NREGS = 32;

  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPCODE_LUI    = 7'b0110111;

  localparam logic [2:0] FUNCT3_ADD  = 3'b000;
  localparam logic [2:0] FUNCT3_SLL  = 3'b001;
  localparam logic [2:0] FUNCT3_SLT  = 3'b010;
  localparam logic [2:0] FUNCT3_SLTU = 3'b011;
  localparam logic [2:0] FUNCT3_XOR  = 3'b100;
  localparam logic [2:0] FUNCT3_SRL  = 3'b101;
  localparam logic [2:0] FUNCT3_OR   = 3'b110;
  localparam logic [2:0] FUNCT3_AND  = 3'b111;

  typedef enum logic [1:0] {
    CLS_OP      = 2'd0,
    CLS_OP_IMM  = 2'd1,
    CLS_LUI     = 2'd2,
    CLS_ILLEGAL = 2'd3
  } instr_class_e;

  typedef struct packed {
    logic [4:0]         rdi;
    logic [RV_XLEN-1:0] a;
    logic [RV_XLEN-1:0] b;
    logic [5:0]         shamt;
    logic [2:0]         funct3;
    logic               invertb;
    logic               out_valid;
    logic               illegal;
  } id_bundle_t;

  function automatic instr_class_e classify(input logic [6:0] opcode);
    instr_class_e cls;
    case (opcode)
      OPCODE_OP:     cls = CLS_OP;
      OPCODE_OP_IMM: cls = CLS_OP_IMM;
      OPCODE_LUI:    cls = CLS_LUI;
      default:       cls = CLS_ILLEGAL;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/riscv_regfile.sv
// 32x32 architectural register file: two combinational reads, one synchronous
// write, asynchronous active-low clear, x0 reads as zero and ignores writes.
module riscv_regfile
  import riscv_id_pkg::*;
#(
  parameter int XLEN  = RV_XLEN,
  parameter int NREGS = RV_NREGS
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [4:0]      ra,
  input  logic [4:0]      rb,
  output logic [XLEN-1:0] rdata_a,
  output logic [XLEN-1:0] rdata_b,
  input  logic            we,
  input  logic [4:0]      wa,
  input  logic [XLEN-1:0] wdata
);

  logic [XLEN-1:0] mem_r [NREGS];

  // Storage: cleared on reset, written on any enabled non-x0 destination.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) begin
        mem_r[i] <= '0;
      end
    end else if (we && (wa != 5'd0)) begin
      mem_r[wa] <= wdata;
    end
  end

  // Read ports: x0 is forced to zero regardless of storage contents.
  always_comb begin
    rdata_a = '0;
    rdata_b = '0;
    if (ra != 5'd0) begin
      rdata_a = mem_r[ra];
    end else begin
      rdata_a = '0;
    end
    if (rb != 5'd0) begin
      rdata_b = mem_r[rb];
    end else begin
      rdata_b = '0;
    end
  end

endmodule

// File: rtl/riscv_id.sv
// RV32I ALU-instruction decode stage: reads operands (with writeback bypass)
// and registers the rdi/a/b/shamt/funct3/invertb bundle for riscv_ex.
module riscv_id
  import riscv_id_pkg::*;
#(
  parameter int XLEN  = RV_XLEN,
  parameter int NREGS = RV_NREGS
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     instr,
  input  logic            instr_valid,
  output logic            ready,
  input  logic            stall,
  input  logic            wb_en,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic [4:0]      rdi,
  output logic [XLEN-1:0] a,
  output logic [XLEN-1:0] b,
  output logic [5:0]      shamt,
  output logic [2:0]      funct3,
  output logic            invertb,
  output logic            out_valid,
  output logic            illegal
);

  logic [4:0]      rs1_s;
  logic [4:0]      rs2_s;
  logic [4:0]      rd_s;
  logic [2:0]      f3_s;
  logic [XLEN-1:0] rf_a_s;
  logic [XLEN-1:0] rf_b_s;
  logic [XLEN-1:0] op_a_s;
  logic [XLEN-1:0] op_b_s;
  logic [XLEN-1:0] imm_i_s;
  logic            is_shift_s;
  id_bundle_t      dec_s;
  id_bundle_t      bundle_r;

  assign rs1_s   = instr[19:15];
  assign rs2_s   = instr[24:20];
  assign rd_s    = instr[11:7];
  assign f3_s    = instr[14:12];
  assign imm_i_s = {{(XLEN-12){instr[31]}}, instr[31:20]};
  assign is_shift_s = (f3_s == FUNCT3_SLL) || (f3_s == FUNCT3_SRL);

  riscv_regfile #(
    .XLEN  (XLEN),
    .NREGS (NREGS)
  ) u_regfile (
    .clk     (clk),
    .rst     (rst),
    .ra      (rs1_s),
    .rb      (rs2_s),
    .rdata_a (rf_a_s),
    .rdata_b (rf_b_s),
    .we      (wb_en),
    .wa      (wb_rd),
    .wdata   (wb_data)
  );

  // Same-cycle writeback bypass onto the operand reads (never for x0).
  always_comb begin
    op_a_s = rf_a_s;
    op_b_s = rf_b_s;
    if (wb_en && (wb_rd == rs1_s) && (rs1_s != 5'd0)) begin
      op_a_s = wb_data;
    end else begin
      op_a_s = rf_a_s;
    end
    if (wb_en && (wb_rd == rs2_s) && (rs2_s != 5'd0)) begin
      op_b_s = wb_data;
    end else begin
      op_b_s = rf_b_s;
    end
  end

  // Decode the presented instruction into the next bundle.
  always_comb begin
    dec_s = '0;
    case (classify(instr[6:0]))
      CLS_OP: begin
        dec_s.rdi       = rd_s;
        dec_s.out_valid = 1'b1;
        dec_s.a         = op_a_s;
        dec_s.funct3    = f3_s;
        if (is_shift_s) begin
          dec_s.b     = '0;
          dec_s.shamt = {1'b0, op_b_s[4:0]};
        end else begin
          dec_s.b     = op_b_s;
          dec_s.shamt = 6'd0;
        end
        if ((f3_s == FUNCT3_ADD) || (f3_s == FUNCT3_SRL)) begin
          dec_s.invertb = instr[30];
        end else begin
          dec_s.invertb = 1'b0;
        end
      end
      CLS_OP_IMM: begin
        dec_s.rdi       = rd_s;
        dec_s.out_valid = 1'b1;
        dec_s.a         = op_a_s;
        dec_s.funct3    = f3_s;
        if (is_shift_s) begin
          dec_s.b       = '0;
          dec_s.shamt   = {1'b0, instr[24:20]};
          dec_s.invertb = (f3_s == FUNCT3_SRL) ? instr[30] : 1'b0;
        end else begin
          dec_s.b       = imm_i_s;
          dec_s.shamt   = 6'd0;
          dec_s.invertb = 1'b0;
        end
      end
      CLS_LUI: begin
        dec_s.rdi       = rd_s;
        dec_s.out_valid = 1'b1;
        dec_s.a         = '0;
        dec_s.b         = {instr[31:12], 12'h000};
        dec_s.funct3    = FUNCT3_ADD;
      end
      default: begin
        dec_s.illegal = 1'b1;
      end
    endcase
  end

  // Output bundle. A stall holds the bundle but still retires the illegal
  // pulse, so illegal is never high for more than one cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bundle_r <= '0;
    end else if (stall) begin
      bundle_r.illegal <= 1'b0;
    end else if (instr_valid) begin
      bundle_r <= dec_s;
    end else begin
      bundle_r <= '0;
    end
  end

  assign ready     = !stall;
  assign rdi       = bundle_r.rdi;
  assign a         = bundle_r.a;
  assign b         = bundle_r.b;
  assign shamt     = bundle_r.shamt;
  assign funct3    = bundle_r.funct3;
  assign invertb   = bundle_r.invertb;
  assign out_valid = bundle_r.out_valid;
  assign illegal   = bundle_r.illegal;

endmodule

// File: doc/riscv_id.md
Name: riscv_id

Overview:
Instruction decode stage, directly upstream of riscv_ex. It accepts one 32-bit RV32I ALU instruction per cycle and reads its operands from an internal register file. It registers the exact operand bundle riscv_ex consumes: rdi, a, b, shamt, funct3 and invertb. Writeback from the end of the pipeline enters through a write port, with same-cycle bypass to the operand reads.

Parameters:
XLEN, 32, datapath width (riscv_ex is fixed at 32; do not override)
NREGS, 32, architectural register count; x0 is hardwired to zero

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-low (0 = reset asserted)
instr  input  32  instruction word
instr_valid  input  1  instr is valid this cycle
ready  output  1  stage accepts instr this cycle; combinational, equals !stall
stall  input  1  downstream hold request
wb_en  input  1  register write enable
wb_rd  input  5  write destination
wb_data  input  32  write data
rdi  output  5  destination register to riscv_ex
a  output  32  operand A
b  output  32  operand B
shamt  output  6  shift amount; bit 5 is always 0
funct3  output  3  ALU operation, using the isa.v FUNCT3_* encoding
invertb  output  1  SUB / arithmetic-shift select
out_valid  output  1  bundle holds a real instruction
illegal  output  1  one-cycle pulse when an unsupported opcode is accepted

Behaviour:
- Reset (rst=0, asynchronous):
  - rdi, a, b, shamt, funct3, invertb, out_valid and illegal all go to 0. The all-zero bundle decodes in riscv_ex as ADD x0 = 0 + 0, i.e. a NOP.
  - Every register-file entry clears to 0.
  - Release is synchronous to the next rising edge.
- Latency: 1 cycle. An instruction accepted at edge N has its bundle valid after edge N.
- Accept: instr_valid & !stall at a rising edge.
- stall=1: all outputs hold their values. The register file still performs writes. Held operands are NOT refreshed; ordering stalls against writeback is the hazard unit's job.
- !stall & !instr_valid: load a bubble (all outputs 0, out_valid=0).
- Decode: rs1=instr[19:15], rs2=instr[24:20], rd=instr[11:7], f3=instr[14:12].
  - OP (0110011): a=R[rs1]; b=R[rs2]; funct3=f3; invertb=instr[30] when f3 is ADD or SRL, otherwise 0.
    - Shifts (f3 = SLL or SRL): shamt={1'b0, R[rs2][4:0]} and b=0.
    - All other f3: shamt=0.
  - OP-IMM (0010011): a=R[rs1]; b=sign-extended instr[31:20]; funct3=f3.
    - SLLI/SRLI/SRAI: shamt={1'b0, instr[24:20]}, b=0, invertb=instr[30] for SRLI/SRAI only.
    - Other f3: invertb=0.
  - LUI (0110111): a=0; b={instr[31:12], 12'b0}; funct3=ADD; invertb=0.
  - rdi=rd and out_valid=1 for all three classes.
  - Any other opcode: load the bubble and set illegal=1 for exactly that one cycle.
- Register file:
  - Two combinational read ports, one synchronous write port.
  - Reading x0 returns 0; a write to x0 is ignored.
  - Bypass: if wb_en and wb_rd==rs and rs!=0 in the same cycle as the read, the operand takes wb_data.
- Simultaneous events:
  - A write and an accept in the same cycle: the write lands and the bypassed value is registered.
  - Reset asserted mid-stall: clears everything; the stall has no effect until reset is released.

Decomposition:
- Opcode constants OPCODE_OP, OPCODE_OP_IMM and OPCODE_LUI are added to isa.v beside the existing FUNCT3_* defines. riscv_ex uses the same funct3 encoding.
- One sub-module, riscv_regfile: 32x32 storage, async active-low clear, 2 read ports, 1 write port, x0 hardwired to 0. The bypass mux stays in riscv_id.

Test Plan:
1. Reset, then wb x1=40 and x2=2; send ADD x4,x1,x2 (0x00208233) -> next cycle: rdi=4, a=40, b=2, funct3=ADD, invertb=0, out_valid=1.
2. SUB x5,x1,x2 (0x402082B3) -> a=40, b=2, invertb=1. ADDI x3,x1,-5 (0xFFB08193) -> b=0xFFFFFFFB, invertb=0.
3. wb x6=3; SLLI x7,x6,2 (0x00231393) -> rdi=7, a=3, b=0, shamt=2, funct3=SLL.
4. Bypass: wb_en=1, wb_rd=1, wb_data=99 in the same cycle as ADD x4,x1,x2 -> a=99. Also ADD x4,x0,x2 with wb_rd=0 -> a=0.
5. Stall: accept ADD, then stall=1 for 3 cycles with a new instr present -> outputs unchanged and ready=0. Release -> the new instr appears 1 cycle later.
6. Opcode 0x0000007F -> illegal=1 for one cycle, out_valid=0. Then drop rst mid-stream -> every output reads 0 with no clock edge needed.
